// File: rtl/snake_engine.sv
// snake_engine: grid snake movement, growth and collision engine.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   game_state                  00 RUNNING, 01/11 DIE (hold), 10 INITIAL (reload)
//   pause, slow                 freeze everything / use TICK_SLOW step period
//   next_direction              requested direction (00 UP, 01 DOWN, 10 RIGHT, 11 LEFT)
//   food_x, food_y              food cell
//   current_direction           direction applied at the last executed step
//   snake_x_flat, snake_y_flat  segment i at [i*COORD_W +: COORD_W], segment 0 = head
//   snake_length                live segment count
//   step, get_food              one-cycle pulses: step executed / food eaten
//   hit_boundary, hit_self      sticky death flags, cleared only by INITIAL
//   full                        snake_length == MAX_LEN
module snake_engine #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int COORD_W   = 5,
  parameter int MAX_LEN   = 64,
  parameter int TICK_FAST = 25_000_000,
  parameter int TICK_SLOW = 50_000_000,
  parameter int WRAP_EN   = 0,
  localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 game_state,
  input  logic                       pause,
  input  logic                       slow,
  input  logic [1:0]                 next_direction,
  input  logic [COORD_W-1:0]         food_x,
  input  logic [COORD_W-1:0]         food_y,
  output logic [1:0]                 current_direction,
  output logic [MAX_LEN*COORD_W-1:0] snake_x_flat,
  output logic [MAX_LEN*COORD_W-1:0] snake_y_flat,
  output logic [LEN_W-1:0]           snake_length,
  output logic                       step,
  output logic                       hit_boundary,
  output logic                       hit_self,
  output logic                       get_food,
  output logic                       full
);

  typedef enum logic [1:0] {GS_RUN = 2'b00, GS_DIE = 2'b01, GS_INIT = 2'b10, GS_DIE_ALT = 2'b11} gs_e;
  typedef enum logic [1:0] {DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_RIGHT = 2'b10, DIR_LEFT = 2'b11} dir_e;
  typedef logic [MAX_LEN-1:0][COORD_W-1:0] seg_t;

  localparam int TICK_MAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
  localparam int CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CNT_W-1:0]   FAST_LAST = CNT_W'(TICK_FAST - 1);
  localparam logic [CNT_W-1:0]   SLOW_LAST = CNT_W'(TICK_SLOW - 1);
  localparam logic [COORD_W-1:0] XMAX      = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMAX      = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] HEAD_X    = COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] HEAD_Y    = COORD_W'(GRID_H / 2 - 1);

  function automatic seg_t init_seg(input logic [COORD_W-1:0] s0, input logic [COORD_W-1:0] s1,
                                    input logic [COORD_W-1:0] s2);
    seg_t s;
    s    = '0;
    s[0] = s0;
    s[1] = s1;
    s[2] = s2;
    return s;
  endfunction

  localparam seg_t INIT_X = init_seg(HEAD_X, HEAD_X, HEAD_X);
  localparam seg_t INIT_Y = init_seg(HEAD_Y, HEAD_Y + COORD_W'(1), HEAD_Y + COORD_W'(2));

  logic [1:0]         rsync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  seg_t               bx_q, bx_d, by_q, by_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               hb_q, hb_d, hs_q, hs_d, step_q, step_d, food_q, food_d;

  gs_e                gs;
  dir_e               nd, ad;
  logic [COORD_W-1:0] cx, cy;
  logic [CNT_W-1:0]   tick_last;
  logic               run_ok, off_grid, eat, is_full, grow, self_hit;
  int unsigned        tail_lim;

  assign gs        = gs_e'(game_state);
  assign run_ok    = rsync_q[1];
  assign tick_last = slow ? SLOW_LAST : FAST_LAST;
  assign is_full   = (len_q == LEN_W'(MAX_LEN));

  // Candidate head, direction filter and collision detection on pre-step state.
  always_comb begin
    nd       = dir_e'(next_direction);
    ad       = (nd == dir_e'(dir_q ^ 2'b01)) ? dir_q : nd;
    cx       = bx_q[0];
    cy       = by_q[0];
    off_grid = 1'b0;
    case (ad)
      DIR_UP:    if (by_q[0] == '0)  begin off_grid = 1'b1; cy = YMAX; end else cy = by_q[0] - COORD_W'(1);
      DIR_DOWN:  if (by_q[0] == YMAX) begin off_grid = 1'b1; cy = '0;   end else cy = by_q[0] + COORD_W'(1);
      DIR_RIGHT: if (bx_q[0] == XMAX) begin off_grid = 1'b1; cx = '0;   end else cx = bx_q[0] + COORD_W'(1);
      default:   if (bx_q[0] == '0)  begin off_grid = 1'b1; cx = XMAX; end else cx = bx_q[0] - COORD_W'(1);
    endcase
    eat  = (cx == food_x) && (cy == food_y);
    grow = eat && !is_full;
    // Segments below tail_lim are obstacles; the tail only counts when it stays put (growth).
    tail_lim = grow ? 32'(len_q) : 32'(len_q) - 1;
    self_hit = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if (i < tail_lim && bx_q[i] == cx && by_q[i] == cy) self_hit = 1'b1;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    bx_d   = bx_q;
    by_d   = by_q;
    len_d  = len_q;
    hb_d   = hb_q;
    hs_d   = hs_q;
    step_d = 1'b0;
    food_d = 1'b0;
    case (gs)
      GS_INIT: begin
        cnt_d = '0;
        dir_d = DIR_UP;
        bx_d  = INIT_X;
        by_d  = INIT_Y;
        len_d = LEN_W'(3);
        hb_d  = 1'b0;
        hs_d  = 1'b0;
      end
      GS_RUN: begin
        if (run_ok && !pause && !hb_q && !hs_q) begin
          if (cnt_q >= tick_last) begin
            cnt_d = '0;
            if (off_grid && WRAP_EN == 0) begin
              hb_d = 1'b1;
            end else if (self_hit) begin
              hs_d = 1'b1;
            end else begin
              // Shifting up to tail_lim also copies the old tail into the new slot on growth.
              for (int unsigned i = 1; i < MAX_LEN; i++) begin
                if (i <= tail_lim) begin
                  bx_d[i] = bx_q[i-1];
                  by_d[i] = by_q[i-1];
                end
              end
              bx_d[0] = cx;
              by_d[0] = cy;
              dir_d   = ad;
              if (grow) len_d = len_q + LEN_W'(1);
              step_d  = 1'b1;
              food_d  = eat;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsync_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      bx_q    <= INIT_X;
      by_q    <= INIT_Y;
      len_q   <= LEN_W'(3);
      hb_q    <= 1'b0;
      hs_q    <= 1'b0;
      step_q  <= 1'b0;
      food_q  <= 1'b0;
    end else begin
      rsync_q <= {rsync_q[0], 1'b1};
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      len_q   <= len_d;
      hb_q    <= hb_d;
      hs_q    <= hs_d;
      step_q  <= step_d;
      food_q  <= food_d;
    end
  end

  assign current_direction = dir_q;
  assign snake_x_flat      = bx_q;
  assign snake_y_flat      = by_q;
  assign snake_length      = len_q;
  assign step              = step_q;
  assign get_food          = food_q;
  assign hit_boundary      = hb_q;
  assign hit_self          = hs_q;
  assign full              = is_full;

endmodule

// File: tb/tb_snake_engine.sv
`timescale 1ns/1ps
module tb_snake_engine;
  localparam int GW = 32, GH = 24, CW = 5, MAXL = 6, TF = 4, TS = 8;
  localparam int LW = $clog2(MAXL + 1);
  localparam int FW = MAXL * CW;
  localparam int DX [4] = '{0, 0, 1, -1};
  localparam int DY [4] = '{-1, 1, 0, 0};
  localparam int OPP[4] = '{1, 0, 3, 2};

  typedef struct {
    logic [FW-1:0] x, y;
    logic [LW-1:0] len;
    logic [1:0]    dir;
    logic          st, gf, hb, hs, fu;
    int            cyc;
  } snap_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] game_state = 2'b10, next_direction = 2'b00;
  logic pause = 1'b0, slow = 1'b0;
  logic [CW-1:0] food_x = 5'd31, food_y = 5'd23;
  logic [1:0] cd [2];
  logic [FW-1:0] sx [2], sy [2];
  logic [LW-1:0] sl [2];
  logic st [2], hb [2], hs [2], gf [2], fu [2];

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  snake_engine #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .MAX_LEN(MAXL), .TICK_FAST(TF), .TICK_SLOW(TS), .WRAP_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .game_state(game_state), .pause(pause), .slow(slow),
    .next_direction(next_direction), .food_x(food_x), .food_y(food_y), .current_direction(cd[0]),
    .snake_x_flat(sx[0]), .snake_y_flat(sy[0]), .snake_length(sl[0]), .step(st[0]),
    .hit_boundary(hb[0]), .hit_self(hs[0]), .get_food(gf[0]), .full(fu[0]));

  snake_engine #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .MAX_LEN(MAXL), .TICK_FAST(TF), .TICK_SLOW(TS), .WRAP_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .game_state(game_state), .pause(pause), .slow(slow),
    .next_direction(next_direction), .food_x(food_x), .food_y(food_y), .current_direction(cd[1]),
    .snake_x_flat(sx[1]), .snake_y_flat(sy[1]), .snake_length(sl[1]), .step(st[1]),
    .hit_boundary(hb[1]), .hit_self(hs[1]), .get_food(gf[1]), .full(fu[1]));

  // Reference model: body as coordinate lists, one per DUT (index 1 = wrap mode).
  int mx [2][MAXL], my [2][MAXL];
  int mlen [2], mdir [2], mcnt [2];
  bit mhb [2], mhs [2];
  snap_t q0[$], q1[$], iq0[$], iq1[$];
  bit done = 1'b0;

  function automatic snap_t model_snap(int m, bit st_e, bit gf_e);
    snap_t s;
    s.x = '0;
    s.y = '0;
    for (int i = 0; i < MAXL; i++) begin
      s.x[i*CW +: CW] = CW'(mx[m][i]);
      s.y[i*CW +: CW] = CW'(my[m][i]);
    end
    s.len = LW'(mlen[m]);
    s.dir = 2'(mdir[m]);
    s.st  = st_e;
    s.gf  = gf_e;
    s.hb  = mhb[m];
    s.hs  = mhs[m];
    s.fu  = (mlen[m] == MAXL);
    s.cyc = cyc + 1;
    return s;
  endfunction

  task automatic push_ev(int m, snap_t s);
    if (m == 0) q0.push_back(s); else q1.push_back(s);
  endtask

  task automatic model_init(int m);
    for (int i = 0; i < MAXL; i++) begin mx[m][i] = 0; my[m][i] = 0; end
    for (int i = 0; i < 3; i++) begin mx[m][i] = GW / 2; my[m][i] = GH / 2 - 1 + i; end
    mlen[m] = 3; mdir[m] = 0; mcnt[m] = 0; mhb[m] = 1'b0; mhs[m] = 1'b0;
  endtask

  // Effect of the coming clock edge under the currently driven inputs.
  task automatic model_cycle(int m, bit wrap);
    int n, ad, nx, ny, lim, nd;
    bit out, eat, grow, hit;
    int tx[MAXL], ty[MAXL];
    if (game_state == 2'b10) model_init(m);
    else if (game_state == 2'b00 && !pause && !mhb[m] && !mhs[m]) begin
      n = slow ? TS : TF;
      if (mcnt[m] != n - 1) mcnt[m]++;
      else begin
        mcnt[m] = 0;
        nd = int'(next_direction);
        ad = (nd == OPP[mdir[m]]) ? mdir[m] : nd;
        nx = mx[m][0] + DX[ad];
        ny = my[m][0] + DY[ad];
        out = nx < 0 || nx >= GW || ny < 0 || ny >= GH;
        if (out && !wrap) begin
          mhb[m] = 1'b1;
          push_ev(m, model_snap(m, 1'b0, 1'b0));
        end else begin
          nx = (nx + GW) % GW;
          ny = (ny + GH) % GH;
          eat  = (nx == int'(food_x)) && (ny == int'(food_y));
          grow = eat && (mlen[m] < MAXL);
          lim  = grow ? mlen[m] - 1 : mlen[m] - 2;
          hit  = 1'b0;
          for (int i = 1; i <= lim; i++) if (mx[m][i] == nx && my[m][i] == ny) hit = 1'b1;
          if (hit) begin
            mhs[m] = 1'b1;
            push_ev(m, model_snap(m, 1'b0, 1'b0));
          end else begin
            for (int i = 0; i < MAXL; i++) begin tx[i] = 0; ty[i] = 0; end
            tx[0] = nx; ty[0] = ny;
            for (int i = 1; i < mlen[m] + int'(grow); i++) begin tx[i] = mx[m][i-1]; ty[i] = my[m][i-1]; end
            for (int i = 0; i < MAXL; i++) begin mx[m][i] = tx[i]; my[m][i] = ty[i]; end
            mlen[m] += int'(grow);
            mdir[m] = ad;
            push_ev(m, model_snap(m, 1'b1, eat));
          end
        end
      end
    end
  endtask

  task automatic tick();
    if (rst_n) begin model_cycle(0, 1'b0); model_cycle(1, 1'b1); end
    @(posedge clk); #1;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic check_now();
    iq0.push_back(model_snap(0, 1'b0, 1'b0));
    iq1.push_back(model_snap(1, 1'b0, 1'b0));
  endtask

  // Monitor / scoreboard: the only process that compares and counts.
  int checks = 0, errors = 0;
  bit pf [2] = '{1'b0, 1'b0};
  snap_t ma, me;

  function automatic snap_t dut_snap(int m);
    snap_t s;
    s.x = sx[m]; s.y = sy[m]; s.len = sl[m]; s.dir = cd[m];
    s.st = st[m]; s.gf = gf[m]; s.hb = hb[m]; s.hs = hs[m]; s.fu = fu[m]; s.cyc = cyc;
    return s;
  endfunction

  task automatic compare(string name, int m, snap_t a, snap_t e, bit wc);
    checks++;
    if (!(a.x === e.x && a.y === e.y && a.len === e.len && a.dir === e.dir && a.st === e.st &&
          a.gf === e.gf && a.hb === e.hb && a.hs === e.hs && a.fu === e.fu && (!wc || a.cyc == e.cyc))) begin
      errors++;
      $display("FAIL %s dut%0d: actual len=%0d dir=%0d step=%0b food=%0b hb=%0b hs=%0b full=%0b cyc=%0d x=%h y=%h, required len=%0d dir=%0d step=%0b food=%0b hb=%0b hs=%0b full=%0b cyc=%0d x=%h y=%h",
               name, m, a.len, a.dir, a.st, a.gf, a.hb, a.hs, a.fu, a.cyc, a.x, a.y,
               e.len, e.dir, e.st, e.gf, e.hb, e.hs, e.fu, e.cyc, e.x, e.y);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m == 0 && iq0.size() > 0) compare("state", 0, dut_snap(0), iq0.pop_front(), 1'b0);
      if (m == 1 && iq1.size() > 0) compare("state", 1, dut_snap(1), iq1.pop_front(), 1'b0);
      if (rst_n && (st[m] || ((hb[m] || hs[m]) && !pf[m]))) begin
        ma = dut_snap(m);
        if ((m == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event dut%0d: actual step=%0b hb=%0b hs=%0b at cycle %0d, required no event",
                   m, st[m], hb[m], hs[m], cyc);
        end else begin
          if (m == 0) me = q0.pop_front(); else me = q1.pop_front();
          compare("event", m, ma, me, 1'b1);
        end
      end
      if (gf[m] && !st[m]) begin
        checks++;
        errors++;
        $display("FAIL food_pulse dut%0d: actual get_food=1 step=0 at cycle %0d, required get_food only with step", m, cyc);
      end
      pf[m] = hb[m] || hs[m];
    end
    if (done) begin
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ((m == 0 ? q0.size() : q1.size()) != 0) begin
          errors++;
          $display("FAIL pending_events dut%0d: actual %0d expected events never seen, required 0",
                   m, (m == 0 ? q0.size() : q1.size()));
        end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual no completion by time limit, required completion");
    $fatal(1, "watchdog");
  end

  task automatic go_init();
    game_state = 2'b10; run(2); game_state = 2'b00;
  endtask

  initial begin
    int fx, fy;
    model_init(0); model_init(1);
    #1 rst_n = 1'b0;
    #1 check_now();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(4); check_now();

    // Steps every 4 clocks heading UP; reversal request ignored.
    game_state = 2'b00; run(12);
    next_direction = 2'b01; run(8);
    next_direction = 2'b00; run(4);          // head (16,5)
    next_direction = 2'b11; run(64);         // head (0,5)
    run(4);                                  // wall death vs wrap to (31,5)
    run(8);
    go_init(); check_now();

    // Growth up to capacity and eating while full.
    food_x = 16; food_y = 10; run(4);
    food_y = 9; run(4);
    food_y = 8; run(4);
    food_y = 7; run(4);
    food_x = 31; food_y = 23; run(4);
    go_init();

    // Length-5 snake turning into segment 3.
    food_x = 16; food_y = 10; run(4);
    food_y = 9; run(4);
    food_x = 31; food_y = 23;
    next_direction = 2'b10; run(4);
    next_direction = 2'b01; run(4);
    next_direction = 2'b11; run(4);
    run(8);
    next_direction = 2'b00; go_init();

    // Length-4 snake chasing its own vacating tail.
    food_x = 16; food_y = 10; run(4);
    food_x = 31; food_y = 23;
    next_direction = 2'b10; run(4);
    next_direction = 2'b01; run(4);
    next_direction = 2'b11; run(4);
    next_direction = 2'b00; run(4);
    next_direction = 2'b10; run(4);
    next_direction = 2'b01; run(4);
    next_direction = 2'b00; go_init();

    // Pause mid-count, then slow stepping.
    run(2); pause = 1'b1; run(10); pause = 1'b0; run(10);
    game_state = 2'b10; slow = 1'b1; run(2); game_state = 2'b00; run(24);
    game_state = 2'b10; slow = 1'b0; run(2); game_state = 2'b00;

    // Reset asserted in the cycle a step is due.
    run(3);
    rst_n = 1'b0; model_init(0); model_init(1);
    #1 check_now();
    @(posedge clk); #1 rst_n = 1'b1;
    game_state = 2'b10; run(4); game_state = 2'b00;

    // Randomized play.
    for (int k = 0; k < 1500; k++) begin
      if (game_state != 2'b00) game_state = 2'b00;
      else if ((mhb[0] || mhs[0] || mhb[1] || mhs[1]) && $urandom_range(0, 5) == 0) game_state = 2'b10;
      else if ($urandom_range(0, 39) == 0) game_state = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      if ($urandom_range(0, 3) == 0) next_direction = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 15) == 0);
      if ((mhb[0] || mhs[0] || mcnt[0] == 0) && (mhb[1] || mhs[1] || mcnt[1] == 0) && $urandom_range(0, 7) == 0)
        slow = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        fx = mx[0][0] + int'($urandom_range(0, 4)) - 2;
        fy = my[0][0] + int'($urandom_range(0, 4)) - 2;
        fx = (fx < 0) ? 0 : (fx > GW - 1) ? GW - 1 : fx;
        fy = (fy < 0) ? 0 : (fy > GH - 1) ? GH - 1 : fy;
        food_x = CW'(fx);
        food_y = CW'(fy);
      end
      tick();
    end
    game_state = 2'b01;
    run(2);
    done = 1'b1;
  end

endmodule
